// File: rtl/easyaxi_rd_slv.sv
// AXI read slave that answers one AR request at a time with address-derived read data.
// Supports FIXED/INCR/WRAP bursts; every R-channel output and arready come straight from flops.
module easyaxi_rd_slv #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int SIZE_W  = 3,
  parameter int BURST_W = 2,
  parameter int RESP_W  = 2,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axi_slv_arvalid,
  output logic               axi_slv_arready,
  input  logic [ID_W-1:0]    axi_slv_arid,
  input  logic [ADDR_W-1:0]  axi_slv_araddr,
  input  logic [LEN_W-1:0]   axi_slv_arlen,
  input  logic [SIZE_W-1:0]  axi_slv_arsize,
  input  logic [BURST_W-1:0] axi_slv_arburst,
  output logic               axi_slv_rvalid,
  input  logic               axi_slv_rready,
  output logic [ID_W-1:0]    axi_slv_rid,
  output logic [DATA_W-1:0]  axi_slv_rdata,
  output logic [RESP_W-1:0]  axi_slv_rresp,
  output logic               axi_slv_rlast
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

  localparam int MAX_SIZE = $clog2(DATA_W / 8);
  localparam logic [BURST_W-1:0] BURST_INCR  = BURST_W'(1'b1);
  localparam logic [BURST_W-1:0] BURST_WRAP  = BURST_W'(2'd2);
  localparam logic [BURST_W-1:0] BURST_RSVD  = BURST_W'(2'd3);
  localparam logic [RESP_W-1:0]  RESP_OKAY   = RESP_W'(2'd0);
  localparam logic [RESP_W-1:0]  RESP_SLVERR = RESP_W'(2'd2);
  localparam logic [RESP_W-1:0]  RESP_DECERR = RESP_W'(2'd3);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0]  addr,
                                                  input logic [LEN_W-1:0]   len,
                                                  input logic [SIZE_W-1:0]  size,
                                                  input logic [BURST_W-1:0] burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    step      = ADDR_W'(1'b1) << size;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1'b1)) << size) - ADDR_W'(1'b1);
    case (burst)
      BURST_INCR: next_addr = (addr & ~(step - ADDR_W'(1'b1))) + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
  endfunction

  // Whole-burst protocol errors: reserved burst, oversized beat, illegal wrap length
  function automatic logic burst_err(input logic [LEN_W-1:0]   len,
                                     input logic [SIZE_W-1:0]  size,
                                     input logic [BURST_W-1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == LEN_W'(1'b1)) || (len == LEN_W'(2'd3)) ||
                  (len == LEN_W'(3'd7)) || (len == LEN_W'(4'd15));
    burst_err = (burst == BURST_RSVD) || (size > SIZE_W'(MAX_SIZE)) ||
                ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  function automatic logic [RESP_W-1:0] beat_resp(input logic err, input logic [ADDR_W-1:0] addr);
    beat_resp = err ? RESP_SLVERR : ((addr >= ADDR_LIMIT) ? RESP_DECERR : RESP_OKAY);
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [RESP_W-1:0] resp,
                                                  input logic [ADDR_W-1:0] addr);
    beat_data = (resp == RESP_OKAY) ? DATA_W'(addr) : {DATA_W{1'b0}};
  endfunction

  state_t             state_r, state_nxt_s;
  logic               arready_r, arready_nxt_s;
  logic               rvalid_r, rvalid_nxt_s;
  logic               rlast_r, rlast_nxt_s;
  logic [ID_W-1:0]    rid_r, rid_nxt_s;
  logic [DATA_W-1:0]  rdata_r, rdata_nxt_s;
  logic [RESP_W-1:0]  rresp_r, rresp_nxt_s;
  logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
  logic [LEN_W-1:0]   len_r, len_nxt_s;
  logic [SIZE_W-1:0]  size_r, size_nxt_s;
  logic [BURST_W-1:0] burst_r, burst_nxt_s;
  logic               err_r, err_nxt_s;
  logic [LEN_W-1:0]   cnt_r, cnt_nxt_s;

  // Next state, captured request fields and the beat to present on R
  always_comb begin
    state_nxt_s   = state_r;
    arready_nxt_s = arready_r;
    rvalid_nxt_s  = rvalid_r;
    rlast_nxt_s   = rlast_r;
    rid_nxt_s     = rid_r;
    addr_nxt_s    = addr_r;
    len_nxt_s     = len_r;
    size_nxt_s    = size_r;
    burst_nxt_s   = burst_r;
    err_nxt_s     = err_r;
    cnt_nxt_s     = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (axi_slv_arvalid && arready_r) begin
          state_nxt_s   = ST_DATA;
          arready_nxt_s = 1'b0;
          rvalid_nxt_s  = 1'b1;
          rid_nxt_s     = axi_slv_arid;
          addr_nxt_s    = axi_slv_araddr;
          len_nxt_s     = axi_slv_arlen;
          size_nxt_s    = axi_slv_arsize;
          burst_nxt_s   = axi_slv_arburst;
          err_nxt_s     = burst_err(axi_slv_arlen, axi_slv_arsize, axi_slv_arburst);
          cnt_nxt_s     = {LEN_W{1'b0}};
          rlast_nxt_s   = (axi_slv_arlen == {LEN_W{1'b0}});
        end else begin
          arready_nxt_s = 1'b1;
          rvalid_nxt_s  = 1'b0;
          rlast_nxt_s   = 1'b0;
        end
      end
      ST_DATA: begin
        if (rvalid_r && axi_slv_rready) begin
          if (rlast_r) begin
            state_nxt_s   = ST_IDLE;
            arready_nxt_s = 1'b1;
            rvalid_nxt_s  = 1'b0;
            rlast_nxt_s   = 1'b0;
          end else begin
            addr_nxt_s  = next_addr(addr_r, len_r, size_r, burst_r);
            cnt_nxt_s   = cnt_r + LEN_W'(1'b1);
            rlast_nxt_s = (cnt_nxt_s == len_r);
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        arready_nxt_s = 1'b0;
        rvalid_nxt_s  = 1'b0;
        rlast_nxt_s   = 1'b0;
      end
    endcase
    // Response and data follow the (possibly held) beat address, so they stay stable under stall
    rresp_nxt_s = beat_resp(err_nxt_s, addr_nxt_s);
    rdata_nxt_s = beat_data(rresp_nxt_s, addr_nxt_s);
  end

  // State, request and R-channel registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= {ID_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= {RESP_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      size_r    <= {SIZE_W{1'b0}};
      burst_r   <= {BURST_W{1'b0}};
      err_r     <= 1'b0;
      cnt_r     <= {LEN_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      arready_r <= arready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      rlast_r   <= rlast_nxt_s;
      rid_r     <= rid_nxt_s;
      rdata_r   <= rdata_nxt_s;
      rresp_r   <= rresp_nxt_s;
      addr_r    <= addr_nxt_s;
      len_r     <= len_nxt_s;
      size_r    <= size_nxt_s;
      burst_r   <= burst_nxt_s;
      err_r     <= err_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  assign axi_slv_arready = arready_r;
  assign axi_slv_rvalid  = rvalid_r;
  assign axi_slv_rlast   = rlast_r;
  assign axi_slv_rid     = rid_r;
  assign axi_slv_rdata   = rdata_r;
  assign axi_slv_rresp   = rresp_r;

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Self-checking bench for easyaxi_rd_slv: directed vector table, multi-cycle corner sequences
// and randomized bursts scored against a closed-form burst model.
module tb_easyaxi_rd_slv;

  logic        clk;
  logic        rst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0][31:0] d;
    logic [3:0][1:0]  r;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[9];

  easyaxi_rd_slv dut (
    .clk             (clk),
    .rst             (rst),
    .axi_slv_arvalid (arvalid),
    .axi_slv_arready (arready),
    .axi_slv_arid    (arid),
    .axi_slv_araddr  (araddr),
    .axi_slv_arlen   (arlen),
    .axi_slv_arsize  (arsize),
    .axi_slv_arburst (arburst),
    .axi_slv_rvalid  (rvalid),
    .axi_slv_rready  (rready),
    .axi_slv_rid     (rid),
    .axi_slv_rdata   (rdata),
    .axi_slv_rresp   (rresp),
    .axi_slv_rlast   (rlast)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard time limit so a stuck DUT cannot hang the run
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats straight from the burst rules: closed-form address per beat index
  function automatic void build_exp(input logic [31:0] addr, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] sz, bnd, lower, a;
    logic        err;
    beat_t       b;
    sz    = 32'd1 << size;
    bnd   = (32'(len) + 32'd1) << size;
    lower = addr & ~(bnd - 32'd1);
    err   = (burst == 2'd3) || (size > 3'd2) ||
            ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    for (int n = 0; n <= int'(len); n++) begin
      case (burst)
        2'd1:    a = (n == 0) ? addr : (addr & ~(sz - 32'd1)) + 32'(n) * sz;
        2'd2:    a = lower | ((addr + 32'(n) * sz) & (bnd - 32'd1));
        default: a = addr;
      endcase
      b.resp = err ? 2'd2 : ((a >= 32'h1000) ? 2'd3 : 2'd0);
      b.data = (b.resp != 2'd0) ? 32'd0 : a;
      b.last = (n == int'(len));
      exp_q.push_back(b);
    end
  endfunction

  function automatic vec_t mkvec(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3,
                                 input logic [1:0] r0, input logic [1:0] r1,
                                 input logic [1:0] r2, input logic [1:0] r3);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    return v;
  endfunction

  // Called just after a negedge with arready expected high; consumes exp_q, ends at a negedge
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit rnd_stall,
                          input int stall_beat, input int stall_len, input bit keep_arvalid);
    int waitc = 0;
    int beat  = 0;
    int stall = 0;
    int iter  = 0;
    beat_t e;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    rready  = 1'b0;
    while (!arready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!arready) begin
      chk("ar_accept_timeout", 64'(arready), 64'd1);
      arvalid = 1'b0;
      exp_q.delete();
      return;
    end
    @(negedge clk);
    if (!keep_arvalid) arvalid = 1'b0;
    while (exp_q.size() > 0 && iter < 4000) begin
      iter++;
      e = exp_q[0];
      chk("rvalid", 64'(rvalid), 64'd1);
      chk("arready_busy", 64'(arready), 64'd0);
      chk("rid", 64'(rid), 64'(id));
      chk($sformatf("rdata_b%0d", beat), 64'(rdata), 64'(e.data));
      chk($sformatf("rresp_b%0d", beat), 64'(rresp), 64'(e.resp));
      chk($sformatf("rlast_b%0d", beat), 64'(rlast), 64'(e.last));
      if (beat == stall_beat && stall < stall_len) begin
        rready = 1'b0;
        stall++;
      end else if (rnd_stall) begin
        rready = ($urandom_range(0, 3) != 0);
      end else begin
        rready = 1'b1;
      end
      if (rready) begin
        void'(exp_q.pop_front());
        beat++;
      end
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      chk("r_beats_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    rready = 1'b0;
    chk("rvalid_after_last", 64'(rvalid), 64'd0);
    chk("arready_after_last", 64'(arready), 64'd1);
    arvalid = 1'b0;
    @(negedge clk);
    chk("ar_not_stored", 64'(rvalid), 64'd0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; arvalid = 1'b0; arid = 4'd0; araddr = 32'd0; arlen = 8'd0;
    arsize = 3'd0; arburst = 2'd0; rready = 1'b0;

    vecs[0] = mkvec(4'd5, 32'h100, 8'd3, 3'd2, 2'd1, 32'h100, 32'h104, 32'h108, 32'h10C, 2'd0, 2'd0, 2'd0, 2'd0);
    vecs[1] = mkvec(4'd1, 32'h38,  8'd3, 3'd2, 2'd2, 32'h38,  32'h3C,  32'h30,  32'h34,  2'd0, 2'd0, 2'd0, 2'd0);
    vecs[2] = mkvec(4'd2, 32'h20,  8'd2, 3'd2, 2'd0, 32'h20,  32'h20,  32'h20,  32'd0,   2'd0, 2'd0, 2'd0, 2'd0);
    vecs[3] = mkvec(4'd3, 32'hFFC, 8'd1, 3'd2, 2'd1, 32'hFFC, 32'd0,   32'd0,   32'd0,   2'd0, 2'd3, 2'd0, 2'd0);
    vecs[4] = mkvec(4'd4, 32'h10,  8'd2, 3'd2, 2'd3, 32'd0,   32'd0,   32'd0,   32'd0,   2'd2, 2'd2, 2'd2, 2'd0);
    vecs[5] = mkvec(4'd6, 32'h40,  8'd2, 3'd2, 2'd2, 32'd0,   32'd0,   32'd0,   32'd0,   2'd2, 2'd2, 2'd2, 2'd0);
    vecs[6] = mkvec(4'd7, 32'h40,  8'd0, 3'd3, 2'd1, 32'd0,   32'd0,   32'd0,   32'd0,   2'd2, 2'd0, 2'd0, 2'd0);
    vecs[7] = mkvec(4'd8, 32'h1000, 8'd0, 3'd2, 2'd0, 32'd0,  32'd0,   32'd0,   32'd0,   2'd3, 2'd0, 2'd0, 2'd0);
    vecs[8] = mkvec(4'd9, 32'h44,  8'd1, 3'd2, 2'd2, 32'h44,  32'h40,  32'd0,   32'd0,   2'd0, 2'd0, 2'd0, 2'd0);

    // Reset values, then arready on the first edge with rst low
    repeat (2) @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_rst", 64'(arready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      for (int b = 0; b <= int'(vecs[i].len); b++) begin
        beat_t t;
        t.data = vecs[i].d[b];
        t.resp = vecs[i].r[b];
        t.last = (b == int'(vecs[i].len));
        exp_q.push_back(t);
      end
      do_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, 1'b0, -1, 0, 1'b0);
    end

    // Stall three cycles on beat 2 with a competing arvalid held high
    build_exp(32'h0, 8'd7, 3'd2, 2'd1);
    do_burst(4'hA, 32'h0, 8'd7, 3'd2, 2'd1, 1'b0, 2, 3, 1'b1);

    // Full-length burst: counter must reach 255 without wrapping early
    build_exp(32'h0, 8'd255, 3'd0, 2'd1);
    do_burst(4'hB, 32'h0, 8'd255, 3'd0, 2'd1, 1'b0, -1, 0, 1'b0);

    // Reset asserted while beat 1 is on the bus
    arvalid = 1'b1; arid = 4'hC; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("mid_b0_rdata", 64'(rdata), 64'h100);
    rready = 1'b1;
    @(negedge clk);
    chk("mid_b1_rdata", 64'(rdata), 64'h104);
    rst = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_arready", 64'(arready), 64'd0);
    chk("mid_rst_rlast", 64'(rlast), 64'd0);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_arready", 64'(arready), 64'd1);
    chk("mid_rel_rvalid", 64'(rvalid), 64'd0);
    build_exp(32'h300, 8'd1, 3'd2, 2'd1);
    do_burst(4'hD, 32'h300, 8'd1, 3'd2, 2'd1, 1'b0, -1, 0, 1'b0);

    // Back-to-back single-beat requests with rready tied high
    rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      arvalid = 1'b1; arid = 4'(k); araddr = 32'h400 + 32'(k) * 32'h10;
      arlen = 8'd0; arsize = 3'd2; arburst = 2'd1;
      chk($sformatf("b2b_arready_%0d", k), 64'(arready), 64'd1);
      @(negedge clk);
      chk($sformatf("b2b_rvalid_%0d", k), 64'(rvalid), 64'd1);
      chk($sformatf("b2b_rlast_%0d", k), 64'(rlast), 64'd1);
      chk($sformatf("b2b_rdata_%0d", k), 64'(rdata), 64'h400 + 64'(k) * 64'h10);
      chk($sformatf("b2b_rid_%0d", k), 64'(rid), 64'(k));
      chk($sformatf("b2b_busy_%0d", k), 64'(arready), 64'd0);
      @(negedge clk);
      chk($sformatf("b2b_gap_%0d", k), 64'(rvalid), 64'd0);
    end
    arvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    chk("b2b_end_rvalid", 64'(rvalid), 64'd0);

    // Randomized bursts with random back-pressure
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  rid_v;
      logic [31:0] addr_v;
      logic [7:0]  len_v;
      logic [2:0]  size_v;
      logic [1:0]  burst_v;
      rid_v   = 4'($urandom_range(0, 15));
      burst_v = 2'($urandom_range(0, 3));
      size_v  = 3'($urandom_range(0, 3));
      addr_v  = 32'($urandom_range(0, 32'h1100));
      if (burst_v == 2'd2 && $urandom_range(0, 3) != 0)
        len_v = 8'((1 << $urandom_range(1, 4)) - 1);
      else
        len_v = 8'($urandom_range(0, 15));
      build_exp(addr_v, len_v, size_v, burst_v);
      do_burst(rid_v, addr_v, len_v, size_v, burst_v, 1'b1, -1, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
